// File: rtl/mult_sequencer.sv
// -----------------------------------------------------------------------------
// mult_sequencer
//   Iterative shift-and-add multiplier. One partial product is accumulated per
//   RUN cycle, a FIX cycle applies the sign, and a DONE cycle presents the
//   2*WIDTH-bit product on {hi, lo} together with a one-cycle prodv pulse.
//   Signed operands are converted to magnitudes on entry, so the datapath is
//   purely unsigned and the sign is restored by a single negation in FIX.
//
// Build option:
//   MULT_EARLY_TERM_EN  - when defined, RUN also ends as soon as the shifted
//                         multiplier register becomes zero (results identical).
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   start  in   request a multiply (only honoured in IDLE)
//   sgn    in   1 = two's complement operands, 0 = unsigned
//   kill   in   abort the operation in flight
//   a, b   in   multiplicand / multiplier (WIDTH bits)
//   busy   out  high whenever the sequencer is not IDLE
//   prodv  out  one-cycle pulse, hi/lo carry a new product this cycle
//   hi, lo out  upper / lower half of the last completed product
//
// States:
//   S_IDLE | waiting for start, hi/lo hold the last product
//   S_RUN  | one shift-and-add step per cycle
//   S_FIX  | negate accumulator if the product is negative, load hi/lo
//   S_DONE | product visible on hi/lo, prodv high
// -----------------------------------------------------------------------------
module mult_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sgn,
    input  logic             kill,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             prodv,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mreg_q, mreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sg_q, sg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   mreg_shift;
    logic               last_run;

    // Negating the most negative value wraps back to itself, which read as an
    // unsigned number is exactly its magnitude 2^(WIDTH-1).
    assign a_mag = (sgn && a[WIDTH-1]) ? -a : a;
    assign b_mag = (sgn && b[WIDTH-1]) ? -b : b;

    assign prod_fix   = sg_q ? -acc_q : acc_q;
    assign mreg_shift = mreg_q >> 1;

    always_comb begin
        last_run = (cnt_q == CNT_LAST);
`ifdef MULT_EARLY_TERM_EN
        // No multiplier bits left: remaining steps would only add zero.
        if (mreg_shift == '0) begin
            last_run = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        mreg_d  = mreg_q;
        cnt_d   = cnt_q;
        sg_d    = sg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && !kill) begin
                    state_d = S_RUN;
                    mcand_d = {{WIDTH{1'b0}}, a_mag};
                    mreg_d  = b_mag;
                    acc_d   = '0;
                    cnt_d   = '0;
                    sg_d    = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                end
            end
            S_RUN: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    if (mreg_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d = mcand_q << 1;
                    mreg_d  = mreg_shift;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (last_run) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    // hi/lo are loaded here so they are already valid in the
                    // DONE cycle where prodv is raised.
                    acc_d   = prod_fix;
                    hi_d    = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d    = prod_fix[WIDTH-1:0];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            mreg_q  <= '0;
            cnt_q   <= '0;
            sg_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mreg_q  <= mreg_d;
            cnt_q   <= cnt_d;
            sg_q    <= sg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign prodv = (state_q == S_DONE);
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mult_sequencer
//   Directed bench for mult_sequencer (WIDTH=32): a table of operand/product
//   vectors followed by hand-written kill, reset and busy-start sequences.
//   Inputs change 1 ns after the rising edge; outputs are read there as well.
// -----------------------------------------------------------------------------
module tb_mult_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         sgn = 1'b0;
    logic         kill = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         prodv;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_pass  = 0;
    int n_total = 0;

    logic [W-1:0] mdl_hi = '0;
    logic [W-1:0] mdl_lo = '0;

    mult_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .sgn   (sgn),
        .kill  (kill),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .prodv (prodv),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs [16];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    endtask

    // Cycles from the start-sampling edge to the prodv cycle: R RUN cycles + 2.
    function automatic int exp_lat(input logic s, input logic [W-1:0] bb);
`ifdef MULT_EARLY_TERM_EN
        logic [W-1:0] mag;
        int r;
        mag = (s && bb[W-1]) ? -bb : bb;
        r = 1;
        for (int i = 0; i < W; i++) if (mag[i]) r = i + 1;
        return r + 2;
`else
        return W + 2;
`endif
    endfunction

    // Issues one multiply from IDLE and waits for prodv (bounded). Checks busy
    // and hi/lo hold during the operation, and the single-cycle pulse after.
    task automatic run_op(input string nm, input logic s, input logic [W-1:0] aa,
                          input logic [W-1:0] bb, output logic [W-1:0] rh,
                          output logic [W-1:0] rl, output int lat);
        int busy_bad;
        int hold_bad;
        busy_bad = 0;
        hold_bad = 0;
        start = 1'b1;
        sgn   = s;
        a     = aa;
        b     = bb;
        tick;
        start = 1'b0;
        a     = ~aa;
        b     = ~bb;
        sgn   = ~s;
        lat   = 1;
        while (!prodv && lat < 200) begin
            if (busy !== 1'b1) busy_bad++;
            if (hi !== mdl_hi || lo !== mdl_lo) hold_bad++;
            tick;
            lat++;
        end
        chk({nm, " busy_during_op_bad_cycles"}, 64'(busy_bad), 64'd0);
        chk({nm, " hilo_changed_before_done"}, 64'(hold_bad), 64'd0);
        chk({nm, " busy_in_done"}, 64'(busy), 64'd1);
        rh = hi;
        rl = lo;
        tick;
        chk({nm, " prodv_after_done"}, 64'(prodv), 64'd0);
        chk({nm, " busy_after_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [W-1:0] rh, rl;
        int lat;

        vecs[0]  = '{1'b0, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F};
        vecs[1]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2]  = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[3]  = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[4]  = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[5]  = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[6]  = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[7]  = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[8]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2};
        vecs[9]  = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000};
        vecs[10] = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
        vecs[11] = '{1'b0, 32'h0000_3039, 32'h0000_0001, 32'h0000_0000, 32'h0000_3039};
        vecs[12] = '{1'b0, 32'h0000_0007, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[13] = '{1'b0, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000};
        vecs[14] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[15] = '{1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000, 32'hFFFE_0001};

        // Reset state
        #12;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset prodv", 64'(prodv), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        tick;
        reset = 1'b1;
        tick;

        // Table vectors
        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, rh, rl, lat);
            chk($sformatf("vec%0d hi", i), 64'(rh), 64'(vecs[i].hi));
            chk($sformatf("vec%0d lo", i), 64'(rl), 64'(vecs[i].lo));
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'(exp_lat(vecs[i].s, vecs[i].b)));
            mdl_hi = vecs[i].hi;
            mdl_lo = vecs[i].lo;
            tick;
        end

        // Kill in RUN at T+10, with a second start at T+5 that must be ignored
        start = 1'b1; sgn = 1'b0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        tick;                                   // T+1
        start = 1'b0;
        repeat (4) tick;                        // T+5
        start = 1'b1; a = 32'h9; b = 32'h9;
        tick;                                   // T+6
        start = 1'b0;
        repeat (4) tick;                        // T+10
        chk("kill_run busy_before", 64'(busy), 64'd1);
        kill = 1'b1;
        tick;                                   // T+11
        kill = 1'b0;
        chk("kill_run busy", 64'(busy), 64'd0);
        begin
            int pv;
            int busy_seen;
            pv = 0;
            busy_seen = 0;
            for (int c = 0; c < 40; c++) begin
                if (prodv) pv++;
                if (busy) busy_seen++;
                tick;
            end
            chk("kill_run no_prodv", 64'(pv), 64'd0);
            chk("kill_run stays_idle", 64'(busy_seen), 64'd0);
        end
        chk("kill_run hi", 64'(hi), 64'(mdl_hi));
        chk("kill_run lo", 64'(lo), 64'(mdl_lo));

        // Kill in FIX (multiplier MSB set so R = W in every build)
        start = 1'b1; sgn = 1'b0; a = 32'h3; b = 32'h8000_0001;
        tick;                                   // T+1
        start = 1'b0;
        repeat (W) tick;                        // T+W+1 = FIX
        chk("kill_fix busy_before", 64'(busy), 64'd1);
        chk("kill_fix prodv_before", 64'(prodv), 64'd0);
        kill = 1'b1;
        tick;
        kill = 1'b0;
        chk("kill_fix busy", 64'(busy), 64'd0);
        chk("kill_fix prodv", 64'(prodv), 64'd0);
        chk("kill_fix hi", 64'(hi), 64'(mdl_hi));
        chk("kill_fix lo", 64'(lo), 64'(mdl_lo));
        tick;

        // Kill and start together in DONE: update still lands, start ignored
        start = 1'b1; sgn = 1'b0; a = 32'h5; b = 32'h8000_0000;
        tick;
        start = 1'b0;
        repeat (W + 1) tick;                    // T+W+2 = DONE
        chk("kill_done prodv", 64'(prodv), 64'd1);
        kill = 1'b1; start = 1'b1; a = 32'h2; b = 32'h2;
        tick;
        kill = 1'b0; start = 1'b0;
        chk("kill_done hi", 64'(hi), 64'h2);
        chk("kill_done lo", 64'(lo), 64'h8000_0000);
        chk("start_in_done ignored", 64'(busy), 64'd0);
        tick;
        chk("start_in_done still_idle", 64'(busy), 64'd0);
        mdl_hi = 32'h2;
        mdl_lo = 32'h8000_0000;

        // Kill together with start in IDLE
        start = 1'b1; kill = 1'b1; a = 32'h4; b = 32'h4;
        tick;
        start = 1'b0; kill = 1'b0;
        chk("kill_start_idle busy", 64'(busy), 64'd0);
        tick;

        // Reset mid-operation at T+20, then start on the first edge after release
        start = 1'b1; sgn = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        tick;
        start = 1'b0;
        repeat (19) tick;                       // T+20
        reset = 1'b0;
        #1;
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset prodv", 64'(prodv), 64'd0);
        chk("midreset hi", 64'(hi), 64'd0);
        chk("midreset lo", 64'(lo), 64'd0);
        mdl_hi = '0;
        mdl_lo = '0;
        tick;
        reset = 1'b1;
        run_op("post_reset", 1'b0, 32'h3, 32'h5, rh, rl, lat);
        chk("post_reset hi", 64'(rh), 64'h0);
        chk("post_reset lo", 64'(rl), 64'hF);
        chk("post_reset latency", 64'(lat), 64'(exp_lat(1'b0, 32'h5)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
